// File: rtl/io_supply_pkg.sv
// Shared definitions for the IO supply sequencer: state encoding and
// default timing parameters.
package io_supply_pkg;

   localparam int SYNC_STAGES_DEF     = 2;
   localparam int DEBOUNCE_CYCLES_DEF = 16;
   localparam int STEP_CYCLES_DEF     = 4;
   localparam int TIMEOUT_CYCLES_DEF  = 1024;

   typedef enum logic [3:0] {
      ST_OFF         = 4'd0,
      ST_WAIT_SUPPLY = 4'd1,
      ST_DEBOUNCE    = 4'd2,
      ST_REL_RET     = 4'd3,
      ST_EN_IE       = 4'd4,
      ST_EN_OE       = 4'd5,
      ST_ON          = 4'd6,
      ST_PWR_DOWN    = 4'd7,
      ST_FAULT       = 4'd8
   } state_e;

endpackage

// File: rtl/io_supply_sync.sv
// Single-bit multi-flop synchronizer for asynchronous level-detector inputs.
module io_supply_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // Shift the raw input one flop deeper each cycle.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d_i};
   end

   // Synchronizer chain, cleared on reset so supplies read as not-good.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/io_supply_seq.sv
// IO ring supply sequencer: waits for synchronized supply-good, debounces it,
// then releases pad retention, input enable and output enable in steps.
// Power-down reverses the order; supply loss after release forces a latched
// fault with all pad controls returned to their safe values.
module io_supply_seq
   import io_supply_pkg::*;
#(
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int STEP_CYCLES     = STEP_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       pwrup_req_i,
   input  logic       vddio_ok_i,
   input  logic       vddx_ok_i,
   input  logic       fault_clr_i,
   output logic       pad_ret_o,
   output logic       pad_ie_o,
   output logic       pad_oe_en_o,
   output logic       ready_o,
   output logic       fault_o,
   output logic [3:0] state_o
);

   localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int STEP_W = $clog2(STEP_CYCLES) + 1;
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES) + 1;

   localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
   localparam logic [STEP_W-1:0] PD_LAST   = STEP_W'(2 * STEP_CYCLES - 1);
   localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT_CYCLES);

   logic vddio_sync;
   logic vddx_sync;
   logic supply_good;

   state_e            state_q,    state_d;
   logic [DEB_W-1:0]  deb_cnt_q,  deb_cnt_d,  deb_inc;
   logic [STEP_W-1:0] step_cnt_q, step_cnt_d, step_inc;
   logic [TMO_W-1:0]  tmo_cnt_q,  tmo_cnt_d,  tmo_inc;
   logic              ret_q,   ret_d;
   logic              ie_q,    ie_d;
   logic              oe_q,    oe_d;
   logic              ready_q, ready_d;
   logic              fault_q, fault_d;

   io_supply_sync #(.STAGES(SYNC_STAGES)) u_sync_vddio (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (vddio_ok_i),
      .q_o   (vddio_sync)
   );

   io_supply_sync #(.STAGES(SYNC_STAGES)) u_sync_vddx (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (vddx_ok_i),
      .q_o   (vddx_sync)
   );

   assign supply_good = vddio_sync & vddx_sync;

   // Saturating increments for all counters; none of them ever wraps.
   always_comb begin
      deb_inc  = (deb_cnt_q == '1)      ? deb_cnt_q  : deb_cnt_q  + 1'b1;
      step_inc = (step_cnt_q == '1)     ? step_cnt_q : step_cnt_q + 1'b1;
      tmo_inc  = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q  : tmo_cnt_q  + 1'b1;
   end

   // Next-state and next-output logic; pad controls change in the same
   // transition that enters the new state, so outputs stay registered.
   always_comb begin
      state_d    = state_q;
      deb_cnt_d  = deb_cnt_q;
      step_cnt_d = step_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      ret_d      = ret_q;
      ie_d       = ie_q;
      oe_d       = oe_q;

      unique case (state_q)
         ST_OFF: begin
            ret_d = 1'b1;
            ie_d  = 1'b0;
            oe_d  = 1'b0;
            if (pwrup_req_i) begin
               state_d   = ST_WAIT_SUPPLY;
               tmo_cnt_d = '0;
               deb_cnt_d = '0;
            end
         end

         ST_WAIT_SUPPLY: begin
            tmo_cnt_d = tmo_inc;
            if (!pwrup_req_i) begin
               state_d = ST_OFF;
            end else if (supply_good) begin
               state_d   = ST_DEBOUNCE;
               deb_cnt_d = '0;
            end else if (tmo_inc == TMO_MAX) begin
               state_d = ST_FAULT;
            end
         end

         ST_DEBOUNCE: begin
            // Timeout keeps running across debounce restarts.
            tmo_cnt_d = tmo_inc;
            if (!supply_good) begin
               state_d   = ST_WAIT_SUPPLY;
               deb_cnt_d = '0;
            end else if (!pwrup_req_i) begin
               state_d = ST_OFF;
            end else if (deb_cnt_q == DEB_MAX) begin
               state_d    = ST_REL_RET;
               step_cnt_d = '0;
               ret_d      = 1'b0;
            end else begin
               deb_cnt_d = deb_inc;
            end
         end

         ST_REL_RET, ST_EN_IE, ST_EN_OE: begin
            step_cnt_d = step_inc;
            if (!supply_good) begin
               state_d = ST_FAULT;
            end else if (!pwrup_req_i) begin
               state_d    = ST_PWR_DOWN;
               step_cnt_d = '0;
               oe_d       = 1'b0;
            end else if (step_cnt_q == STEP_LAST) begin
               step_cnt_d = '0;
               if (state_q == ST_REL_RET) begin
                  state_d = ST_EN_IE;
                  ie_d    = 1'b1;
               end else if (state_q == ST_EN_IE) begin
                  state_d = ST_EN_OE;
                  oe_d    = 1'b1;
               end else begin
                  state_d = ST_ON;
               end
            end
         end

         ST_ON: begin
            if (!supply_good) begin
               state_d = ST_FAULT;
            end else if (!pwrup_req_i) begin
               state_d    = ST_PWR_DOWN;
               step_cnt_d = '0;
               oe_d       = 1'b0;
            end
         end

         ST_PWR_DOWN: begin
            step_cnt_d = step_inc;
            if (!supply_good) begin
               state_d = ST_FAULT;
            end else if (step_cnt_q == PD_LAST) begin
               state_d = ST_OFF;
               ret_d   = 1'b1;
               ie_d    = 1'b0;
            end else if (step_cnt_q == STEP_LAST) begin
               ie_d = 1'b0;
            end
         end

         ST_FAULT: begin
            if (fault_clr_i && !pwrup_req_i) begin
               state_d = ST_OFF;
            end
         end

         default: begin
            state_d = ST_OFF;
         end
      endcase

      // Any entry into FAULT drops every pad control to safe in that edge.
      if (state_d == ST_FAULT) begin
         ret_d = 1'b1;
         ie_d  = 1'b0;
         oe_d  = 1'b0;
      end

      ready_d = (state_d == ST_ON);
      fault_d = (state_d == ST_FAULT);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_OFF;
         deb_cnt_q  <= '0;
         step_cnt_q <= '0;
         tmo_cnt_q  <= '0;
         ret_q      <= 1'b1;
         ie_q       <= 1'b0;
         oe_q       <= 1'b0;
         ready_q    <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         deb_cnt_q  <= deb_cnt_d;
         step_cnt_q <= step_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         ret_q      <= ret_d;
         ie_q       <= ie_d;
         oe_q       <= oe_d;
         ready_q    <= ready_d;
         fault_q    <= fault_d;
      end
   end

   assign pad_ret_o   = ret_q;
   assign pad_ie_o    = ie_q;
   assign pad_oe_en_o = oe_q;
   assign ready_o     = ready_q;
   assign fault_o     = fault_q;
   assign state_o     = state_q;

endmodule
